// File: rtl/ggt_arbiter.sv
// ggt_arbiter: round-robin sharing of one ggt_top GCD engine among N_REQ requesters.
// Zero operands are answered directly without starting the engine.
// Optional engine watchdog: define GGT_TIMEOUT_EN (uses TIMEOUT_CYCLES).
module ggt_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*WIDTH-1:0] req_zahl1_i,
  input  logic [N_REQ*WIDTH-1:0] req_zahl2_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic [N_REQ-1:0]       rsp_valid_o,
  output logic [WIDTH-1:0]       rsp_ergebnis_o,
  output logic                   rsp_err_o,
  output logic                   busy_o,
  output logic                   eng_rst_o,
  output logic                   eng_start_o,
  output logic [WIDTH-1:0]       eng_zahl1_o,
  output logic [WIDTH-1:0]       eng_zahl2_o,
  input  logic                   eng_valid_i,
  input  logic [WIDTH-1:0]       eng_ergebnis_i
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_found;
  logic [N_REQ-1:0] gnt_oh;
  logic [WIDTH-1:0] z1_arr [N_REQ];
  logic [WIDTH-1:0] z2_arr [N_REQ];
  logic [WIDTH-1:0] z1_d, z2_d, res_d;
  logic             armed_q, armed_d;
  logic [N_REQ-1:0] rsp_valid_d;
  logic             start_d, busy_d;
  logic             done_c, timeout_c;
  int unsigned      cand;

  // Elaboration guard on the supported parameter range
  if (N_REQ < 2 || N_REQ > 8 || WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ggt_arbiter: parameter out of range");
  end

  // Unpack per-requester operand slices and form the one-hot grant
  for (genvar g = 0; g < N_REQ; g++) begin : g_req
    assign z1_arr[g] = req_zahl1_i[g*WIDTH +: WIDTH];
    assign z2_arr[g] = req_zahl2_i[g*WIDTH +: WIDTH];
    assign gnt_oh[g] = gnt_found && (gnt_idx == IDX_W'(g));
  end

  // Round-robin search starting just above the last granted requester
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!gnt_found && req_valid_i[IDX_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

  assign req_ready_o    = (state_q == S_IDLE) ? gnt_oh : '0;
  assign done_c         = armed_q && eng_valid_i;

`ifdef GGT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             to_q;

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err_o = to_q;
  assign eng_rst_o = ~rst_i | to_q;

  // Watchdog counter over WAIT; to_q marks the RESP cycle that follows a timeout
  always_ff @(posedge clk) begin
    if (!rst_i) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      if (state_q == S_START) cnt_q <= '0;
      else if (state_q == S_WAIT) cnt_q <= cnt_q + CNT_W'(1);
      to_q <= (state_q == S_WAIT) && !done_c && timeout_c;
    end
  end
`else
  assign timeout_c = 1'b0;
  assign rsp_err_o = 1'b0;
  assign eng_rst_o = ~rst_i;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    armed_d = armed_q;
    z1_d    = eng_zahl1_o;
    z2_d    = eng_zahl2_o;
    res_d   = rsp_ergebnis_o;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          ptr_d = gnt_idx;
          idx_d = gnt_idx;
          z1_d  = z1_arr[gnt_idx];
          z2_d  = z2_arr[gnt_idx];
          if (z1_arr[gnt_idx] == '0 || z2_arr[gnt_idx] == '0) begin
            // gcd(0,x)=x; with one operand zero the OR is the other operand
            res_d   = z1_arr[gnt_idx] | z2_arr[gnt_idx];
            state_d = S_RESP;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        armed_d = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A valid level still high from the previous job is ignored until it drops
        if (!eng_valid_i) armed_d = 1'b1;
        if (done_c) begin
          res_d   = eng_ergebnis_i;
          state_d = S_RESP;
        end else if (timeout_c) begin
          res_d   = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    for (int unsigned k = 0; k < N_REQ; k++) begin
      rsp_valid_d[k] = (state_d == S_RESP) && (idx_d == IDX_W'(k));
    end
    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state_q        <= S_IDLE;
      ptr_q          <= IDX_W'(N_REQ - 1);
      idx_q          <= '0;
      armed_q        <= 1'b0;
      eng_zahl1_o    <= '0;
      eng_zahl2_o    <= '0;
      rsp_ergebnis_o <= '0;
      rsp_valid_o    <= '0;
      eng_start_o    <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      idx_q          <= idx_d;
      armed_q        <= armed_d;
      eng_zahl1_o    <= z1_d;
      eng_zahl2_o    <= z2_d;
      rsp_ergebnis_o <= res_d;
      rsp_valid_o    <= rsp_valid_d;
      eng_start_o    <= start_d;
      busy_o         <= busy_d;
    end
  end

endmodule

// File: tb/tb_ggt_arbiter.sv
// Testbench for ggt_arbiter with a behavioural GCD engine stub.
// Define GGT_TIMEOUT_EN to also exercise the watchdog path.
module tb_ggt_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned TO = 16;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_valid_i;
  logic [N*W-1:0] req_zahl1_i;
  logic [N*W-1:0] req_zahl2_i;
  logic [N-1:0]   req_ready_o;
  logic [N-1:0]   rsp_valid_o;
  logic [W-1:0]   rsp_ergebnis_o;
  logic           rsp_err_o;
  logic           busy_o;
  logic           eng_rst_o;
  logic           eng_start_o;
  logic [W-1:0]   eng_zahl1_o;
  logic [W-1:0]   eng_zahl2_o;
  logic           eng_valid_i;
  logic [W-1:0]   eng_ergebnis_i;

  int checks   = 0;
  int failures = 0;
  int eng_mode = 0;   // 0: normal gcd, 1: stale valid then 9, 2: never valid
  int n_starts = 0;

  ggt_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_zahl1_i    (req_zahl1_i),
    .req_zahl2_i    (req_zahl2_i),
    .req_ready_o    (req_ready_o),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ergebnis_o (rsp_ergebnis_o),
    .rsp_err_o      (rsp_err_o),
    .busy_o         (busy_o),
    .eng_rst_o      (eng_rst_o),
    .eng_start_o    (eng_start_o),
    .eng_zahl1_o    (eng_zahl1_o),
    .eng_zahl2_o    (eng_zahl2_o),
    .eng_valid_i    (eng_valid_i),
    .eng_ergebnis_i (eng_ergebnis_i)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    req_zahl1_i[k*W +: W] = a;
    req_zahl2_i[k*W +: W] = b;
    req_valid_i[k]        = 1'b1;
  endtask

  task automatic do_reset();
    rst_i       = 1'b0;
    req_valid_i = '0;
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  // Engine stub: reacts at the falling edge to the registered start pulse
  initial begin : engine
    int cd;
    int stale;
    eng_valid_i    = 1'b0;
    eng_ergebnis_i = '0;
    cd             = 0;
    stale          = 0;
    forever begin
      @(negedge clk);
      if (eng_rst_o) begin
        eng_valid_i = 1'b0;
        cd          = 0;
        stale       = 0;
      end else if (eng_start_o) begin
        n_starts++;
        if (eng_mode == 1) begin
          eng_valid_i    = 1'b1;
          eng_ergebnis_i = 16'd77;
          stale          = 5;
        end else begin
          eng_valid_i = 1'b0;
          cd          = (eng_mode == 0) ? int'($urandom_range(2, 7)) : 0;
          stale       = 0;
        end
      end else if (stale > 0) begin
        stale--;
        if (stale == 3) eng_valid_i = 1'b0;
        if (stale == 0) begin
          eng_valid_i    = 1'b1;
          eng_ergebnis_i = 16'd9;
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          eng_valid_i    = 1'b1;
          eng_ergebnis_i = gcd_ref(eng_zahl1_o, eng_zahl2_o);
        end
      end
    end
  end

  // One job on requester k: grant, start/bypass timing, response and return to idle
  task automatic run_job(input string name, input int k, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input bit bypass);
    int s0;
    bit seen;
    logic [31:0] oh;
    oh = 32'(1) << k;
    tick();
    s0 = n_starts;
    set_req(k, a, b);
    #1;
    chk({name, " ready"}, 32'(req_ready_o), oh);
    tick();
    req_valid_i[k] = 1'b0;
    if (bypass) begin
      chk({name, " bypass rsp_valid"}, 32'(rsp_valid_o), oh);
      chk({name, " bypass result"}, 32'(rsp_ergebnis_o), 32'(exp));
      chk({name, " bypass no start"}, 32'(eng_start_o), 0);
      chk({name, " bypass busy"}, 32'(busy_o), 1);
    end else begin
      chk({name, " start"}, 32'(eng_start_o), 1);
      chk({name, " zahl1"}, 32'(eng_zahl1_o), 32'(a));
      chk({name, " zahl2"}, 32'(eng_zahl2_o), 32'(b));
      seen = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
        tick();
        if (rsp_valid_o != '0) seen = 1'b1;
      end
      chk({name, " rsp seen"}, 32'(seen), 1);
      chk({name, " rsp_valid"}, 32'(rsp_valid_o), oh);
      chk({name, " result"}, 32'(rsp_ergebnis_o), 32'(exp));
      chk({name, " zahl1 held"}, 32'(eng_zahl1_o), 32'(a));
    end
    chk({name, " err"}, 32'(rsp_err_o), 0);
    tick();
    chk({name, " busy low"}, 32'(busy_o), 0);
    chk({name, " rsp pulse 1 cycle"}, 32'(rsp_valid_o), 0);
    chk({name, " start count"}, 32'(n_starts - s0), bypass ? 32'd0 : 32'd1);
  endtask

  // Randomized traffic against a queue-based model of grant order and gcd results
  task automatic run_random(input int n_cycles);
    int           exp_k[$];
    logic [W-1:0] exp_r[$];
    logic [W-1:0] ra[N];
    logic [W-1:0] rb[N];
    int           mptr, last, g, c;
    mptr = N - 1;
    last = -1;
    for (int k = 0; k < N; k++) begin
      ra[k] = '0;
      rb[k] = '0;
    end
    for (int cyc = 0; cyc < n_cycles + 3000; cyc++) begin
      tick();
      if (last >= 0) begin
        req_valid_i[last] = 1'b0;
        last = -1;
      end
      if (cyc >= n_cycles && req_valid_i == '0 && exp_k.size() == 0) break;
      if (cyc < n_cycles) begin
        for (int k = 0; k < N; k++) begin
          if (!req_valid_i[k] && $urandom_range(0, 2) == 0) begin
            ra[k] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            rb[k] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            set_req(k, ra[k], rb[k]);
          end
        end
      end
      #1;
      if (rsp_valid_o != '0) begin
        if (exp_k.size() == 0) begin
          chk("rnd spurious rsp", 32'(rsp_valid_o), 0);
        end else begin
          chk("rnd rsp index", 32'(rsp_valid_o), 32'(1) << exp_k[0]);
          chk("rnd rsp value", 32'(rsp_ergebnis_o), 32'(exp_r[0]));
          void'(exp_k.pop_front());
          void'(exp_r.pop_front());
        end
      end
      if (req_ready_o != '0) begin
        g = -1;
        for (int i = 1; i <= N; i++) begin
          c = (mptr + i) % N;
          if (g < 0 && req_valid_i[c]) g = c;
        end
        chk("rnd grant", 32'(req_ready_o), (g < 0) ? 32'd0 : (32'(1) << g));
        if (g >= 0) begin
          mptr = g;
          exp_k.push_back(g);
          exp_r.push_back(gcd_ref(ra[g], rb[g]));
          last = g;
        end
      end
    end
    chk("rnd drained", 32'(exp_k.size() + $countones(req_valid_i)), 0);
  endtask

  typedef struct {
    int           k;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    bit           bypass;
  } job_t;

  job_t         jobs[9];
  logic [W-1:0] sa[N];
  logic [W-1:0] sb[N];
  logic [W-1:0] sr[N];
  int           c;
  int           rsp_cnt;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    jobs[0] = '{0, 16'd24255, 16'd12540, 16'd165,   1'b0};
    jobs[1] = '{2, 16'd0,     16'd35,    16'd35,    1'b1};
    jobs[2] = '{2, 16'd0,     16'd0,     16'd0,     1'b1};
    jobs[3] = '{1, 16'd35,    16'd0,     16'd35,    1'b1};
    jobs[4] = '{3, 16'd65535, 16'd65535, 16'd65535, 1'b0};
    jobs[5] = '{1, 16'd1,     16'd65535, 16'd1,     1'b0};
    jobs[6] = '{3, 16'd40000, 16'd60000, 16'd20000, 1'b0};
    jobs[7] = '{0, 16'd65535, 16'd0,     16'd65535, 1'b1};
    jobs[8] = '{2, 16'd48,    16'd18,    16'd6,     1'b0};

    req_zahl1_i = '0;
    req_zahl2_i = '0;
    rst_i       = 1'b0;
    req_valid_i = '0;
    tick();
    tick();
    chk("reset busy", 32'(busy_o), 0);
    chk("reset rsp_valid", 32'(rsp_valid_o), 0);
    chk("reset ready", 32'(req_ready_o), 0);
    chk("reset start", 32'(eng_start_o), 0);
    chk("reset eng_rst", 32'(eng_rst_o), 1);
    chk("reset err", 32'(rsp_err_o), 0);
    chk("reset result", 32'(rsp_ergebnis_o), 0);
    chk("reset zahl1", 32'(eng_zahl1_o), 0);
    rst_i = 1'b1;
    #1;
    chk("eng_rst released", 32'(eng_rst_o), 0);

    eng_mode = 0;
    for (int i = 0; i < 9; i++) begin
      run_job($sformatf("job%0d", i), jobs[i].k, jobs[i].a, jobs[i].b, jobs[i].exp, jobs[i].bypass);
    end

    eng_mode = 1;
    run_job("stale", 1, 16'd27, 16'd18, 16'd9, 1'b0);
    eng_mode = 0;

    // Reset while waiting on the engine abandons the job
    tick();
    set_req(3, 16'd100, 16'd75);
    tick();
    req_valid_i[3] = 1'b0;
    chk("midrst start", 32'(eng_start_o), 1);
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk("midrst eng_rst", 32'(eng_rst_o), 1);
    tick();
    chk("midrst busy", 32'(busy_o), 0);
    chk("midrst rsp_valid", 32'(rsp_valid_o), 0);
    chk("midrst zahl1", 32'(eng_zahl1_o), 0);
    chk("midrst result", 32'(rsp_ergebnis_o), 0);
    rst_i   = 1'b1;
    rsp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid_o != '0) rsp_cnt++;
    end
    chk("midrst no response", 32'(rsp_cnt), 0);

    // All four requesters at once: served 0,1,2,3
    sa[0] = 16'd48;  sb[0] = 16'd18; sr[0] = 16'd6;
    sa[1] = 16'd35;  sb[1] = 16'd14; sr[1] = 16'd7;
    sa[2] = 16'd17;  sb[2] = 16'd5;  sr[2] = 16'd1;
    sa[3] = 16'd100; sb[3] = 16'd75; sr[3] = 16'd25;
    tick();
    for (int k = 0; k < N; k++) set_req(k, sa[k], sb[k]);
    #1;
    for (int g = 0; g < N; g++) begin
      c = 0;
      while (req_ready_o == '0 && c < 60) begin
        tick();
        c++;
      end
      chk($sformatf("multi grant %0d", g), 32'(req_ready_o), 32'(1) << g);
      tick();
      req_valid_i[g] = 1'b0;
      c = 0;
      while (rsp_valid_o == '0 && c < 60) begin
        tick();
        c++;
      end
      chk($sformatf("multi rsp_valid %0d", g), 32'(rsp_valid_o), 32'(1) << g);
      chk($sformatf("multi result %0d", g), 32'(rsp_ergebnis_o), 32'(sr[g]));
    end

    do_reset();
    run_random(1500);

`ifdef GGT_TIMEOUT_EN
    eng_mode = 2;
    tick();
    set_req(1, 16'd12, 16'd8);
    tick();
    req_valid_i[1] = 1'b0;
    chk("to start", 32'(eng_start_o), 1);
    c = 0;
    while (rsp_valid_o == '0 && c < 100) begin
      tick();
      c++;
    end
    chk("to latency", 32'(c), 32'(TO + 1));
    chk("to rsp_valid", 32'(rsp_valid_o), 32'b0010);
    chk("to result", 32'(rsp_ergebnis_o), 0);
    chk("to err", 32'(rsp_err_o), 1);
    chk("to eng_rst pulse", 32'(eng_rst_o), 1);
    tick();
    chk("to eng_rst end", 32'(eng_rst_o), 0);
    chk("to err end", 32'(rsp_err_o), 0);
    chk("to idle", 32'(busy_o), 0);
    eng_mode = 0;
    run_job("after_to", 2, 16'd21, 16'd14, 16'd7, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
